// File: rtl/key_scan_ctrl.sv
// -----------------------------------------------------------------------------
// key_scan_ctrl
//   Debounces N_KEYS active-low raw keys, turns debounced level changes into
//   press/release events and queues them in a 4-deep show-ahead FIFO. Events
//   waiting for FIFO space are held per key and granted round-robin.
//
// Ports
//   clk        system clock, all state on the rising edge
//   clr        asynchronous active-high reset
//   key_n      raw asynchronous keys, 0 = pressed
//   key_state  debounced level per key, 1 = pressed
//   evt_valid  FIFO head valid
//   evt_ready  consumer accepts the head (pop on evt_valid & evt_ready)
//   evt_key    key index of the head event (0 when empty)
//   evt_rel    head event is a release (0 when empty)
//   evt_long   head event is a long press (0 when empty)
//   ovf        sticky flag: a pending event was overwritten before queueing
//   ovf_clr    synchronous clear of ovf
//
// Build option
//   KEY_SCAN_LONG_PRESS_EN  when defined, per-key hold counters generate one
//                           long-press event after LONG_TICKS ticks held.
//                           When undefined, no hold counters exist and
//                           evt_long is tied to 0.
// -----------------------------------------------------------------------------
module key_scan_ctrl #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned LONG_TICKS = 1000
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [N_KEYS-1:0]         key_n,
  output logic [N_KEYS-1:0]         key_state,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_key,
  output logic                      evt_rel,
  output logic                      evt_long,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int unsigned KEY_W = $clog2(N_KEYS);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  if (N_KEYS < 2 || N_KEYS > 16 || TICK_DIV < 8 || LONG_TICKS < 1) begin : g_param_check
    $error("key_scan_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2
  } evt_type_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    evt_type_e        etype;
  } evt_entry_t;

  // Synchronizer, prescaler, debounce
  logic [N_KEYS-1:0] sync1_q, sync2_q, pressed;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic [2:0]        hist_q [N_KEYS];
  logic [2:0]        hist_d [N_KEYS];
  logic [N_KEYS-1:0] key_state_q, key_state_d;

  // Pending events and arbiter
  logic [N_KEYS-1:0] new_evt, pending_q, pending_d;
  evt_type_e         new_type [N_KEYS];
  evt_type_e         ptype_q  [N_KEYS];
  evt_type_e         ptype_d  [N_KEYS];
  logic [KEY_W-1:0]  rr_q, rr_d, grant_idx, scan_idx;
  logic              grant_vld, lost;
  logic              ovf_q, ovf_d;

  // FIFO
  evt_entry_t        fifo_mem_q [4];
  evt_entry_t        push_entry, head;
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              push, pop, full;

  assign pressed = ~sync2_q;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values computed above them; only clocked blocks use '<='.
    tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    key_state_d = key_state_q;
    for (int i = 0; i < N_KEYS; i++) begin
      hist_d[i] = hist_q[i];
      if (tick) begin
        hist_d[i] = {hist_q[i][1:0], pressed[i]};
        // The freshly shifted history decides, so three agreeing samples
        // change the level on the third tick.
        if (hist_d[i] == 3'b111)      key_state_d[i] = 1'b1;
        else if (hist_d[i] == 3'b000) key_state_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      new_evt[i]  = (key_state_d[i] != key_state_q[i]);
      new_type[i] = key_state_d[i] ? EVT_PRESS : EVT_RELEASE;
    end
  end

`ifdef KEY_SCAN_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);

  logic [HOLD_W-1:0] hold_q [N_KEYS];
  logic [HOLD_W-1:0] hold_d [N_KEYS];
  logic [N_KEYS-1:0] long_evt;

  always_comb begin
    long_evt = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      hold_d[i] = hold_q[i];
      if (!key_state_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && hold_q[i] != HOLD_W'(LONG_TICKS)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        // Saturation at LONG_TICKS makes this fire once per press; a release
        // on the same tick takes precedence.
        long_evt[i] = (hold_d[i] == HOLD_W'(LONG_TICKS)) && key_state_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N_KEYS; i++) hold_q[i] <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // Round-robin grant: scan from rr_q upward; descending loop lets the
  // closest pending index win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = N_KEYS - 1; k >= 0; k--) begin
      scan_idx = KEY_W'((int'(rr_q) + k) % N_KEYS);
      if (pending_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign full = (count_q == 3'd4);
  assign pop  = evt_valid & evt_ready;
  assign push = grant_vld & (~full | pop);

  always_comb begin
    rr_d = rr_q;
    if (push) rr_d = (grant_idx == KEY_W'(N_KEYS - 1)) ? '0 : grant_idx + 1'b1;

    push_entry.key   = grant_idx;
    push_entry.etype = ptype_q[grant_idx];

    wr_ptr_d = wr_ptr_q + 2'(push);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    count_d  = count_q + 3'(push) - 3'(pop);
  end

  always_comb begin
    pending_d = pending_q;
    ptype_d   = ptype_q;
    lost      = 1'b0;
    // Clear the granted bit first so an event arriving in the grant cycle is
    // kept rather than counted as lost.
    if (push) pending_d[grant_idx] = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (new_evt[i]) begin
        lost         = lost | pending_d[i];
        pending_d[i] = 1'b1;
        ptype_d[i]   = new_type[i];
      end
`ifdef KEY_SCAN_LONG_PRESS_EN
      if (long_evt[i]) begin
        lost         = lost | pending_d[i];
        pending_d[i] = 1'b1;
        ptype_d[i]   = EVT_LONG;
      end
`endif
    end
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (lost)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      cnt_q       <= '0;
      key_state_q <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        hist_q[i]  <= '0;
        ptype_q[i] <= EVT_PRESS;
      end
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      key_state_q <= key_state_d;
      pending_q   <= pending_d;
      ptype_q     <= ptype_d;
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the FIFO storage is not reset; count_q gates every read, so stale
  // contents never reach the outputs and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

  assign head      = fifo_mem_q[rd_ptr_q];
  assign evt_valid = (count_q != 3'd0);
  assign evt_key   = evt_valid ? head.key : '0;
  assign evt_rel   = evt_valid && (head.etype == EVT_RELEASE);
`ifdef KEY_SCAN_LONG_PRESS_EN
  assign evt_long  = evt_valid && (head.etype == EVT_LONG);
`else
  assign evt_long  = 1'b0;
`endif
  assign key_state = key_state_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_scan_ctrl
//   Directed bench for key_scan_ctrl with N_KEYS=4, TICK_DIV=8, LONG_TICKS=4.
//   cyc counts rising edges since clr was released, so tick edges are the
//   edges where cyc is a multiple of 8. Inputs change and outputs are sampled
//   on the falling edge after edge cyc. A key driven right after a tick edge
//   reaches key_state 24 cycles later; its event heads the FIFO one cycle
//   after that.
// -----------------------------------------------------------------------------
module tb_key_scan_ctrl;

`ifdef KEY_SCAN_LONG_PRESS_EN
  localparam logic LONG_EN = 1'b1;
`else
  localparam logic LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] key_n = 4'b1111;
  logic [3:0] key_state;
  logic       evt_valid, evt_ready, evt_rel, evt_long, ovf, ovf_clr;
  logic [1:0] evt_key;

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  int mon_valid = 0;
  int mon_ks = 0;

  key_scan_ctrl #(.N_KEYS(4), .TICK_DIV(8), .LONG_TICKS(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .key_n     (key_n),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_rel   (evt_rel),
    .evt_long  (evt_long),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge after rising edge c, tallying cycles with a
  // valid head or any key pressed along the way.
  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (evt_valid)       mon_valid++;
      if (key_state != 0)  mon_ks++;
    end
    if (guard >= 2000) check("wait_cyc_timeout", cyc, c);
  endtask

  initial begin
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key_state", key_state, 4'b0000);
    check("rst_evt_valid", evt_valid, 1'b0);
    check("rst_evt_key",   evt_key,   2'd0);
    check("rst_evt_rel",   evt_rel,   1'b0);
    check("rst_ovf",       ovf,       1'b0);

    // Single held key 2
    clr = 1'b0;
    key_n[2] = 1'b0;
    wait_cyc(23); check("k2_before_tick3", key_state, 4'b0000);
    wait_cyc(24); check("k2_state_tick3",  key_state, 4'b0100);
                  check("k2_no_evt_yet",   evt_valid, 1'b0);
    wait_cyc(25); check("k2_evt_valid",    evt_valid, 1'b1);
                  check("k2_evt_key",      evt_key,   2'd2);
                  check("k2_evt_rel",      evt_rel,   1'b0);
                  check("k2_evt_long",     evt_long,  1'b0);
    wait_cyc(26); check("k2_popped",       evt_valid, 1'b0);
    mon_valid = 0;
    wait_cyc(40); check("k2_no_more_evts", mon_valid, 0);
    key_n[2] = 1'b1;
    wait_cyc(80); check("k2_released",     key_state, 4'b0000);
                  check("k2_fifo_idle",    evt_valid, 1'b0);

    // Key 0 toggling every tick never settles
    mon_valid = 0;
    mon_ks    = 0;
    for (int k = 0; k < 10; k++) begin
      wait_cyc(80 + 8 * k);
      key_n[0] = k[0];
    end
    wait_cyc(184);
    check("bounce_no_state", mon_ks,    0);
    check("bounce_no_evt",   mon_valid, 0);

    // Re-baseline: round-robin pointer back to 0
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Keys 0,1,3 pressed together, consumer stalled
    evt_ready = 1'b0;
    key_n = 4'b0100;
    wait_cyc(23); check("multi_before",     key_state, 4'b0000);
    wait_cyc(24); check("multi_state",      key_state, 4'b1011);
                  check("multi_no_evt_yet", evt_valid, 1'b0);
    wait_cyc(25); check("multi_head0",      evt_key,   2'd0);
    wait_cyc(28); check("multi_hold_valid", evt_valid, 1'b1);
                  check("multi_hold_key0",  evt_key,   2'd0);
    evt_ready = 1'b1;
    wait_cyc(29); check("multi_pop_key1",   evt_key,   2'd1);
                  check("multi_pop_rel",    evt_rel,   1'b0);
    wait_cyc(30); check("multi_pop_key3",   evt_key,   2'd3);
    wait_cyc(31); check("multi_empty",      evt_valid, 1'b0);
    wait_cyc(32);
    key_n = 4'b1111;
    wait_cyc(64); check("multi_released",   key_state, 4'b0000);
                  check("multi_drained",    evt_valid, 1'b0);

    // FIFO full, releases pending, overwrite of key 0
    evt_ready = 1'b0;
    key_n = 4'b0000;
    wait_cyc(88);  check("full_state",       key_state, 4'b1111);
    wait_cyc(92);  check("full_valid",       evt_valid, 1'b1);
                   check("full_head_key0",   evt_key,   2'd0);
    wait_cyc(96);
    key_n = 4'b1111;
    wait_cyc(121); check("rel_state",        key_state, 4'b0000);
                   check("rel_head_key0",    evt_key,   2'd0);
                   check("rel_head_press",   evt_rel,   1'b0);
                   check("rel_no_ovf",       ovf,       1'b0);
    key_n = 4'b1110;
    wait_cyc(143); check("ovf_before",       ovf,       1'b0);
    wait_cyc(144); check("ovf_set",          ovf,       1'b1);
                   check("ovf_key0_state",   key_state, 4'b0001);
    evt_ready = 1'b1;
    wait_cyc(145); check("drain_key1",       evt_key,   2'd1);
    wait_cyc(146); check("drain_key2",       evt_key,   2'd2);
    wait_cyc(147); check("drain_key3",       evt_key,   2'd3);
    wait_cyc(148); check("drain_k0_key",     evt_key,   2'd0);
                   check("drain_k0_press",   evt_rel,   1'b0);
    wait_cyc(149); check("drain_k1_key",     evt_key,   2'd1);
                   check("drain_k1_rel",     evt_rel,   1'b1);
    wait_cyc(151); check("drain_k3_key",     evt_key,   2'd3);
                   check("drain_k3_rel",     evt_rel,   1'b1);
    wait_cyc(152); check("drain_empty",      evt_valid, 1'b0);
                   check("ovf_sticky",       ovf,       1'b1);
    ovf_clr = 1'b1;
    wait_cyc(153); check("ovf_cleared",      ovf,       1'b0);
    ovf_clr = 1'b0;
    key_n = 4'b1111;
    wait_cyc(184); check("ovf_sect_idle",    evt_valid, 1'b0);
                   check("ovf_sect_state",   key_state, 4'b0000);

    // Long hold of key 1 (10 ticks)
    key_n = 4'b1101;
    wait_cyc(208); check("long_state",       key_state, 4'b0010);
    wait_cyc(209); check("long_press_key",   evt_key,   2'd1);
                   check("long_press_rel",   evt_rel,   1'b0);
                   check("long_press_long",  evt_long,  1'b0);
    wait_cyc(210); check("long_press_pop",   evt_valid, 1'b0);
    mon_valid = 0;
    wait_cyc(240); check("long_quiet_before", mon_valid, 0);
    wait_cyc(241); check("long_evt_valid",   evt_valid, LONG_EN);
                   check("long_evt_long",    evt_long,  LONG_EN);
                   check("long_evt_key",     evt_key,   LONG_EN ? 2'd1 : 2'd0);
                   check("long_evt_rel",     evt_rel,   1'b0);
    mon_valid = 0;
    wait_cyc(264);
    key_n = 4'b1111;
    wait_cyc(288); check("long_only_once",   mon_valid, 0);
                   check("long_released",    key_state, 4'b0000);
    wait_cyc(289); check("long_rel_key",     evt_key,   2'd1);
                   check("long_rel_rel",     evt_rel,   1'b1);
                   check("long_rel_long",    evt_long,  1'b0);

    // Asynchronous clear with two queued events
    wait_cyc(296);
    evt_ready = 1'b0;
    key_n = 4'b1100;
    wait_cyc(320); check("clr_pre_state",    key_state, 4'b0011);
    wait_cyc(322); check("clr_pre_valid",    evt_valid, 1'b1);
                   check("clr_pre_key",      evt_key,   2'd0);
    key_n = 4'b1111;
    #2 clr = 1'b1;
    #1;
    check("clr_async_valid", evt_valid, 1'b0);
    check("clr_async_state", key_state, 4'b0000);
    check("clr_async_ovf",   ovf,       1'b0);
    check("clr_async_key",   evt_key,   2'd0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    evt_ready = 1'b1;
    mon_valid = 0;
    mon_ks    = 0;
    wait_cyc(60);
    check("post_clr_no_evt",   mon_valid, 0);
    check("post_clr_no_state", mon_ks,    0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
